// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the register-file context bank (clear-engine state enum)
package ibex_pkg;
  typedef enum logic {CTX_CLR_IDLE, CTX_CLR_CLEAR} ctx_clr_state_e;
endpackage

// File: rtl/ibex_rf_ctx_clr.sv
// ibex_rf_ctx_clr: background context clear engine; takes req/idx/ctx_sel, drives busy/done/err and the clr_we/clr_ctx/clr_addr write port
module ibex_rf_ctx_clr import ibex_pkg::*; #(
  parameter int NumRegFiles = 4,
  parameter int NumRegs     = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [$clog2(NumRegFiles)-1:0] rf_ctx_sel_i,
  input  logic                           ctx_clr_req_i,
  input  logic [$clog2(NumRegFiles)-1:0] ctx_clr_idx_i,
  output logic                           ctx_clr_busy_o,
  output logic                           ctx_clr_done_o,
  output logic                           ctx_clr_err_o,
  output logic                           clr_we,
  output logic [$clog2(NumRegFiles)-1:0] clr_ctx,
  output logic [4:0]                     clr_addr
);
  localparam int CtxW = $clog2(NumRegFiles);
  ctx_clr_state_e state_q, state_d;
  logic [4:0] ptr_q, ptr_d;
  logic [CtxW-1:0] idx_q, idx_d;
  logic done_q, done_d, err_q, err_d, last, accept, reject;
  assign last   = ptr_q == 5'(NumRegs - 1);
  assign accept = ctx_clr_req_i && ctx_clr_idx_i != rf_ctx_sel_i;
  assign reject = ctx_clr_req_i && ctx_clr_idx_i == rf_ctx_sel_i;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CTX_CLR_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (state_q == CTX_CLR_IDLE) begin
      state_d = accept ? CTX_CLR_CLEAR : CTX_CLR_IDLE;
      idx_d   = accept ? ctx_clr_idx_i : idx_q;
      ptr_d   = accept ? 5'd1 : ptr_q;
      err_d   = reject;
    end else begin
      state_d = last ? CTX_CLR_IDLE : CTX_CLR_CLEAR;
      ptr_d   = last ? 5'd0 : ptr_q + 5'd1;
      done_d  = last;
    end
  end
  assign ctx_clr_busy_o = state_q == CTX_CLR_CLEAR;
  assign ctx_clr_done_o = done_q;
  assign ctx_clr_err_o  = err_q;
  assign clr_we         = state_q == CTX_CLR_CLEAR;
  assign clr_ctx        = idx_q;
  assign clr_addr       = ptr_q;
endmodule

// File: rtl/ibex_rf_ctx_bank.sv
// ibex_rf_ctx_bank: multi-context flop register file; 2 comb read ports + 1 write port on rf_ctx_sel_i, plus background context clear (busy/done/err)
module ibex_rf_ctx_bank import ibex_pkg::*; #(
  parameter int                NumRegFiles = 4,
  parameter bit                RV32E       = 1'b0,
  parameter int                DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [$clog2(NumRegFiles)-1:0] rf_ctx_sel_i,
  input  logic [4:0]                     rf_raddr_a_i,
  output logic [DataWidth-1:0]           rf_rdata_a_ecc_o,
  input  logic [4:0]                     rf_raddr_b_i,
  output logic [DataWidth-1:0]           rf_rdata_b_ecc_o,
  input  logic [4:0]                     rf_waddr_wb_i,
  input  logic                           rf_we_wb_i,
  input  logic [DataWidth-1:0]           rf_wdata_wb_ecc_i,
  input  logic                           ctx_clr_req_i,
  input  logic [$clog2(NumRegFiles)-1:0] ctx_clr_idx_i,
  output logic                           ctx_clr_busy_o,
  output logic                           ctx_clr_done_o,
  output logic                           ctx_clr_err_o
);
  localparam int NumRegs = RV32E ? 16 : 32;
  localparam int RegAw   = RV32E ? 4 : 5;
  localparam int CtxW    = $clog2(NumRegFiles);
  logic [DataWidth-1:0] mem_q [NumRegFiles][NumRegs];
  logic [NumRegs-1:0] core_we [NumRegFiles];
  logic [NumRegs-1:0] reg_we [NumRegFiles];
  logic clr_we;
  logic [CtxW-1:0] clr_ctx;
  logic [4:0] clr_addr;
  ibex_rf_ctx_clr #(
    .NumRegFiles(NumRegFiles),
    .NumRegs    (NumRegs)
  ) u_clr (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rf_ctx_sel_i  (rf_ctx_sel_i),
    .ctx_clr_req_i (ctx_clr_req_i),
    .ctx_clr_idx_i (ctx_clr_idx_i),
    .ctx_clr_busy_o(ctx_clr_busy_o),
    .ctx_clr_done_o(ctx_clr_done_o),
    .ctx_clr_err_o (ctx_clr_err_o),
    .clr_we        (clr_we),
    .clr_ctx       (clr_ctx),
    .clr_addr      (clr_addr)
  );
  always_comb begin
    for (int c = 0; c < NumRegFiles; c++) begin
      core_we[c] = '0;
      reg_we[c]  = '0;
      for (int r = 1; r < NumRegs; r++) begin
        core_we[c][r] = rf_we_wb_i && rf_ctx_sel_i == CtxW'(c) && rf_waddr_wb_i == 5'(r);
        reg_we[c][r]  = (rf_we_wb_i && rf_ctx_sel_i == CtxW'(c) && rf_waddr_wb_i == 5'(r)) ||
                        (clr_we && clr_ctx == CtxW'(c) && clr_addr == 5'(r));
      end
    end
  end
  // x0 is only ever reset, never written, so it always reads WordZeroVal
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumRegFiles; c++)
        for (int r = 0; r < NumRegs; r++)
          mem_q[c][r] <= WordZeroVal;
    end else begin
      for (int c = 0; c < NumRegFiles; c++)
        for (int r = 1; r < NumRegs; r++)
          if (reg_we[c][r]) mem_q[c][r] <= core_we[c][r] ? rf_wdata_wb_ecc_i : WordZeroVal;
    end
  end
  assign rf_rdata_a_ecc_o = (RV32E && rf_raddr_a_i[4]) ? WordZeroVal :
                            mem_q[rf_ctx_sel_i][rf_raddr_a_i[RegAw-1:0]];
  assign rf_rdata_b_ecc_o = (RV32E && rf_raddr_b_i[4]) ? WordZeroVal :
                            mem_q[rf_ctx_sel_i][rf_raddr_b_i[RegAw-1:0]];
endmodule
